// File: rtl/clk_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : clk_freq_meter
// Description : Measures period and high time of a slow asynchronous input in
//               clk cycles, with sticky loss-of-input detection. Optional
//               period tolerance check via CLK_FREQ_METER_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_freq_meter #(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 1000,
  parameter int EXP_PERIOD = 10,
  parameter int TOL        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output logic             freq_err
);

  localparam logic [1:0]       c_IDLE    = 2'd0;
  localparam logic [1:0]       c_ARM     = 2'd1;
  localparam logic [1:0]       c_MEASURE = 2'd2;
  localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rise;
  logic             w_fall;
  logic             w_measure;
  logic             w_cnt_at_limit;

  assign w_rise         = r_s2 & ~r_s3;
  assign w_fall         = ~r_s2 & r_s3;
  assign w_measure      = en && (r_state == c_MEASURE);
  assign w_cnt_at_limit = (r_cnt == c_TIMEOUT);

  // Two-flop synchronizer followed by a history flop for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= clk_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_IDLE;
      r_cnt      <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!en) begin
        r_state <= c_IDLE;
        r_cnt   <= '0;
        timeout <= 1'b0;
      end else begin
        case (r_state)
          c_IDLE: begin
            r_cnt   <= '0;
            r_state <= c_ARM;
          end
          c_ARM: begin
            if (w_rise) begin
              r_cnt   <= c_ONE;
              r_state <= c_MEASURE;
            end
          end
          c_MEASURE: begin
            r_cnt <= r_cnt + c_ONE;
            if (w_fall) begin
              high_time <= r_cnt;
            end
            // A rise on the limit cycle still counts: TIMEOUT is the longest legal period.
            if (w_rise) begin
              period     <= r_cnt;
              r_cnt      <= c_ONE;
              meas_valid <= 1'b1;
              timeout    <= 1'b0;
            end else if (w_cnt_at_limit) begin
              timeout <= 1'b1;
              r_cnt   <= '0;
              r_state <= c_ARM;
            end
          end
          default: begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

`ifdef CLK_FREQ_METER_CHECK_EN
  localparam int c_HI_LIMIT = EXP_PERIOD + TOL;
  localparam int c_LO_LIMIT = EXP_PERIOD - TOL;

  logic w_freq_bad;

  assign w_freq_bad = (int'(r_cnt) > c_HI_LIMIT) || (int'(r_cnt) < c_LO_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      freq_err <= 1'b0;
    end else if (!en) begin
      freq_err <= 1'b0;
    end else if (w_measure) begin
      if (w_rise) begin
        freq_err <= w_freq_bad;
      end else if (w_cnt_at_limit) begin
        freq_err <= 1'b1;
      end
    end
  end
`else
  // Tolerance parameters stay referenced so both builds share one interface.
  assign freq_err = 1'b0 & (EXP_PERIOD < 0) & (TOL < 0) & w_measure;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_freq_meter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_clk_freq_meter
// Description : Randomized bench for clk_freq_meter against a timestamp model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_freq_meter;
  localparam int CNT_W      = 16;
  localparam int TIMEOUT    = 1000;
  localparam int EXP_PERIOD = 10;
  localparam int TOL        = 1;

  logic             clk    = 1'b0;
  logic             rst    = 1'b1;
  logic             en     = 1'b1;
  logic             clk_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             timeout;
  logic             freq_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  clk_freq_meter #(
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .EXP_PERIOD(EXP_PERIOD), .TOL(TOL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clk_in(clk_in),
    .period(period), .high_time(high_time), .meas_valid(meas_valid),
    .timeout(timeout), .freq_err(freq_err)
  );

  // Model: input samples taken 1/2/3 edges ago and the edge index of the last
  // detected rise; intervals are edge-index differences.
  int     m_mode;          // 0 idle, 1 waiting for first rise, 2 measuring
  longint cyc;
  longint last_rise;
  int     e_period, e_high;
  bit     e_mv, e_to, e_fe;
  bit     h1, h2, h3;

  task automatic model_reset();
    m_mode = 0; cyc = 0; last_rise = 0;
    e_period = 0; e_high = 0; e_mv = 0; e_to = 0; e_fe = 0;
    h1 = 0; h2 = 0; h3 = 0;
  endtask

  task automatic model_step();
    bit     rise, fall;
    longint age;
    rise = h2 & ~h3;
    fall = ~h2 & h3;
    h3 = h2; h2 = h1; h1 = clk_in;
    cyc++;
    age  = cyc - last_rise;
    e_mv = 0;
    if (!en) begin
      m_mode = 0; e_to = 0; e_fe = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (rise) begin
        last_rise = cyc;
        m_mode = 2;
      end
    end else begin
      if (fall) e_high = int'(age);
      if (rise) begin
        e_period  = int'(age);
        last_rise = cyc;
        e_mv = 1;
        e_to = 0;
`ifdef CLK_FREQ_METER_CHECK_EN
        e_fe = (age > EXP_PERIOD + TOL) || (age < EXP_PERIOD - TOL);
`endif
      end else if (age == TIMEOUT) begin
        e_to   = 1;
        m_mode = 1;
`ifdef CLK_FREQ_METER_CHECK_EN
        e_fe = 1;
`endif
      end
    end
  endtask

  always @(negedge rst) model_reset();

  always begin
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    #1;
    vectors++;
    if (period !== CNT_W'(e_period) || high_time !== CNT_W'(e_high) ||
        meas_valid !== e_mv || timeout !== e_to || freq_err !== e_fe) begin
      miscompares++;
      $display("FAIL cycle_check t=%0t: got period=%0d high=%0d mv=%b to=%b fe=%b, expected %0d %0d %b %b %b",
               $time, period, high_time, meas_valid, timeout, freq_err,
               e_period, e_high, e_mv, e_to, e_fe);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      clk_in = 1'b1;
      repeat (hi) @(negedge clk);
      clk_in = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("reset_period", int'(period), 0);
    chk("reset_timeout", int'(timeout), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    wave(5, 5, 6);
    chk("div10_period", int'(period), 10);
    chk("div10_high", int'(high_time), 5);
    chk("div10_timeout", int'(timeout), 0);

    wave(250, 250, 3);
    chk("div500_period", int'(period), 500);
    chk("div500_high", int'(high_time), 250);

    wave(5, 5, 3);
    repeat (1100) @(negedge clk);
    chk("loss_timeout", int'(timeout), 1);
    wave(5, 5, 1);
    chk("timeout_held_until_valid", int'(timeout), 1);
    wave(5, 5, 3);
    chk("timeout_cleared", int'(timeout), 0);
    chk("restart_period", int'(period), 10);

    clk_in = 1'b1;
    repeat (25) @(negedge clk);
    clk_in = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midreset_period", int'(period), 0);
    chk("midreset_high", int'(high_time), 0);
    chk("midreset_valid", int'(meas_valid), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (14) @(negedge clk);
    wave(25, 25, 1);
    chk("first_rise_no_result", int'(period), 0);
    wave(25, 25, 2);
    chk("div50_period", int'(period), 50);
    chk("div50_high", int'(high_time), 25);

    wave(5, 5, 3);
    en = 1'b0;
    wave(5, 5, 2);
    chk("en_low_period_hold", int'(period), 10);
    chk("en_low_timeout", int'(timeout), 0);
    en = 1'b1;
    wave(5, 5, 4);
    chk("en_resume_period", int'(period), 10);

    wave(500, 500, 3);
    chk("max_period", int'(period), TIMEOUT);
    chk("max_period_no_timeout", int'(timeout), 0);

    wave(6, 5, 4);
    chk("period11", int'(period), 11);
`ifdef CLK_FREQ_METER_CHECK_EN
    chk("period11_ferr", int'(freq_err), 0);
`endif
    wave(7, 6, 3);
    chk("period13", int'(period), 13);
`ifdef CLK_FREQ_METER_CHECK_EN
    chk("period13_ferr", int'(freq_err), 1);
`endif
    wave(5, 5, 3);
    chk("period10_again", int'(period), 10);
`ifdef CLK_FREQ_METER_CHECK_EN
    chk("period10_ferr", int'(freq_err), 0);
`endif

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) en = ~en;
      if ($urandom_range(0, 15) == 0) begin
        clk_in = 1'b0;
        repeat (1010) @(negedge clk);
      end
      wave($urandom_range(1, 30), $urandom_range(1, 30), $urandom_range(1, 3));
    end
    en = 1'b1;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
